// File: rtl/fwrisc_mem_arbiter.sv
// fwrisc_mem_arbiter
//   Shares one single-ported memory bus between the fwrisc instruction-fetch
//   port and data port. One transaction in flight at a time; round-robin
//   arbitration on simultaneous requests; a watchdog forces completion of
//   transactions whose memory never answers.
//
// Ports:
//   clock, reset                  clock (rising edge), async active-low reset
//   iaddr/ivalid -> iready/idata  fetch request / completion pulse + read data
//   daddr/dvalid/dwrite/dwdata/dwstb -> dready/drdata
//                                 data request / completion pulse + read data
//   maddr/mvalid/mwrite/mwdata/mwstb  registered memory request
//   mrdata/mready                 memory response
//   bus_err                       one-cycle pulse on watchdog expiry
//   grant_d                       high while the data port owns the bus
module fwrisc_mem_arbiter #(
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] iaddr,
    input  logic        ivalid,
    output logic        iready,
    output logic [31:0] idata,
    input  logic [31:0] daddr,
    input  logic        dvalid,
    input  logic        dwrite,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwstb,
    output logic        dready,
    output logic [31:0] drdata,
    output logic [31:0] maddr,
    output logic        mvalid,
    output logic        mwrite,
    output logic [31:0] mwdata,
    output logic [3:0]  mwstb,
    input  logic [31:0] mrdata,
    input  logic        mready,
    output logic        bus_err,
    output logic        grant_d
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
    localparam logic        WDOG_EN     = (TIMEOUT != 0);

    state_t      state, state_next;
    logic        last_grant_d;   // 1 = data port won the last arbitration
    logic [15:0] wdog;
    logic [31:0] idata_q, drdata_q;

    logic        take_i, take_d;
    logic        done, timeout;
    logic [31:0] rdata_sel;

    // Next-state, arbitration and combinational completion outputs.
    always_comb begin
        state_next = state;
        take_i     = 1'b0;
        take_d     = 1'b0;
        done       = 1'b0;
        timeout    = 1'b0;
        unique case (state)
            IDLE: begin
                // On contention, the port that did not win last time goes next.
                take_i = ivalid && (!dvalid || last_grant_d);
                take_d = dvalid && !take_i;
                if (take_i)      state_next = BUSY_I;
                else if (take_d) state_next = BUSY_D;
            end
            BUSY_I, BUSY_D: begin
                timeout = WDOG_EN && (wdog == TIMEOUT_CNT) && !mready;
                done    = mready || timeout;
                if (done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign rdata_sel = timeout ? ERR_RDATA : mrdata;
    assign iready    = done && (state == BUSY_I);
    assign dready    = done && (state == BUSY_D);
    assign idata     = iready ? rdata_sel : idata_q;
    assign drdata    = dready ? rdata_sel : drdata_q;
    assign bus_err   = timeout;
    assign grant_d   = (state == BUSY_D);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            last_grant_d <= 1'b1;
            wdog         <= '0;
            maddr        <= '0;
            mvalid       <= 1'b0;
            mwrite       <= 1'b0;
            mwdata       <= '0;
            mwstb        <= '0;
            idata_q      <= '0;
            drdata_q     <= '0;
        end else begin
            state <= state_next;
            if (take_i) begin
                maddr        <= iaddr;
                mwrite       <= 1'b0;
                mwdata       <= '0;
                mwstb        <= '1;
                mvalid       <= 1'b1;
                last_grant_d <= 1'b0;
                wdog         <= '0;
            end else if (take_d) begin
                maddr        <= daddr;
                mwrite       <= dwrite;
                mwdata       <= dwdata;
                mwstb        <= dwstb;
                mvalid       <= 1'b1;
                last_grant_d <= 1'b1;
                wdog         <= '0;
            end else if (done) begin
                mvalid <= 1'b0;
            end else if (state != IDLE) begin
                wdog <= wdog + 16'd1;
            end
            if (iready) idata_q  <= rdata_sel;
            if (dready) drdata_q <= rdata_sel;
        end
    end

endmodule

// File: tb/tb_fwrisc_mem_arbiter.sv
// tb_fwrisc_mem_arbiter
//   Directed self-checking bench for fwrisc_mem_arbiter (TIMEOUT=4).
//   Inputs change 1ns after the rising edge; outputs are checked after a
//   further settling delay, never on the edge itself.
module tb_fwrisc_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] iaddr, daddr, dwdata, mrdata;
    logic        ivalid, dvalid, dwrite, mready;
    logic [3:0]  dwstb;
    logic        iready, dready, mvalid, mwrite, bus_err, grant_d;
    logic [31:0] idata, drdata, maddr, mwdata;
    logic [3:0]  mwstb;

    int checks   = 0;
    int failures = 0;

    fwrisc_mem_arbiter #(.TIMEOUT(4), .ERR_RDATA(32'hDEAD_BEEF)) dut (
        .clock(clock), .reset(reset),
        .iaddr(iaddr), .ivalid(ivalid), .iready(iready), .idata(idata),
        .daddr(daddr), .dvalid(dvalid), .dwrite(dwrite), .dwdata(dwdata),
        .dwstb(dwstb), .dready(dready), .drdata(drdata),
        .maddr(maddr), .mvalid(mvalid), .mwrite(mwrite), .mwdata(mwdata),
        .mwstb(mwstb), .mrdata(mrdata), .mready(mready),
        .bus_err(bus_err), .grant_d(grant_d)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    // Waits (bounded) for a grant, answers it in the first busy cycle and
    // checks the completion pulse; returns the number of steps waited.
    task automatic serve(input string tag, input logic exp_d, input logic [31:0] rd,
                         output int waited);
        waited = 0;
        while (mvalid !== 1'b1 && waited < 8) begin
            step;
            waited++;
        end
        check({tag, "_mvalid"}, {31'd0, mvalid}, 32'd1);
        check({tag, "_grant_d"}, {31'd0, grant_d}, {31'd0, exp_d});
        mready = 1'b1;
        mrdata = rd;
        #1;
        check({tag, "_iready"}, {31'd0, iready}, {31'd0, !exp_d});
        check({tag, "_dready"}, {31'd0, dready}, {31'd0, exp_d});
        check({tag, "_rdata"}, exp_d ? drdata : idata, rd);
        step;
        mready = 1'b0;
    endtask

    initial begin
        int w;
        reset = 1'b0;
        iaddr = '0; daddr = '0; dwdata = '0; mrdata = '0; dwstb = '0;
        ivalid = 1'b0; dvalid = 1'b0; dwrite = 1'b0; mready = 1'b0;

        // Reset state
        #3;
        check("rst_mvalid", {31'd0, mvalid}, 32'd0);
        check("rst_grant_d", {31'd0, grant_d}, 32'd0);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);
        check("rst_ready", {30'd0, iready, dready}, 32'd0);
        check("rst_maddr", maddr, 32'd0);
        check("rst_mwstb", {28'd0, mwstb}, 32'd0);
        check("rst_idata", idata, 32'd0);
        check("rst_drdata", drdata, 32'd0);
        step; step;
        reset = 1'b1;

        // Single fetch, memory answers in the third busy cycle
        ivalid = 1'b1; iaddr = 32'h100;
        step;
        check("f_mvalid", {31'd0, mvalid}, 32'd1);
        check("f_maddr", maddr, 32'h100);
        check("f_mwstb", {28'd0, mwstb}, 32'hF);
        check("f_mwrite", {31'd0, mwrite}, 32'd0);
        check("f_mwdata", mwdata, 32'd0);
        step; step;
        mready = 1'b1; mrdata = 32'h13;
        #1;
        check("f_iready", {31'd0, iready}, 32'd1);
        check("f_idata", idata, 32'h13);
        check("f_dready", {31'd0, dready}, 32'd0);
        ivalid = 1'b0;
        step;
        mready = 1'b0; mrdata = 32'h77;
        #1;
        check("f_mvalid_off", {31'd0, mvalid}, 32'd0);
        check("f_iready_off", {31'd0, iready}, 32'd0);
        check("f_idata_hold", idata, 32'h13);

        // Contention straight after reset: I, D, I, D with back-to-back gaps
        reset = 1'b0;
        step;
        reset = 1'b1;
        ivalid = 1'b1; iaddr = 32'h500;
        dvalid = 1'b1; daddr = 32'h600; dwrite = 1'b0;
        for (int k = 0; k < 4; k++) begin
            serve("rr", (k % 2) == 1, 32'h1000 + k, w);
            check("rr_gap", w, 32'd1);
        end
        ivalid = 1'b0; dvalid = 1'b0;
        #1;
        check("rr_idle", {31'd0, mvalid}, 32'd0);

        // Data write
        step;
        dvalid = 1'b1; daddr = 32'h2004; dwdata = 32'hA5A5A5A5; dwstb = 4'b0011; dwrite = 1'b1;
        step;
        check("w_mvalid", {31'd0, mvalid}, 32'd1);
        check("w_maddr", maddr, 32'h2004);
        check("w_mwdata", mwdata, 32'hA5A5A5A5);
        check("w_mwstb", {28'd0, mwstb}, 32'h3);
        check("w_mwrite", {31'd0, mwrite}, 32'd1);
        check("w_grant_d", {31'd0, grant_d}, 32'd1);
        mready = 1'b1; mrdata = 32'h0;
        #1;
        check("w_dready", {31'd0, dready}, 32'd1);
        check("w_iready", {31'd0, iready}, 32'd0);
        dvalid = 1'b0;
        step;
        mready = 1'b0;

        // Timeout: read never answered; expiry in the fifth busy cycle
        dvalid = 1'b1; daddr = 32'h3000; dwrite = 1'b0; dwstb = 4'hF;
        step;
        for (int c = 0; c < 4; c++) begin
            check("to_no_err", {30'd0, bus_err, dready}, 32'd0);
            step;
        end
        check("to_dready", {31'd0, dready}, 32'd1);
        check("to_drdata", drdata, 32'hDEADBEEF);
        check("to_bus_err", {31'd0, bus_err}, 32'd1);
        check("to_iready", {31'd0, iready}, 32'd0);
        dvalid = 1'b0;
        step;
        check("to_mvalid_off", {31'd0, mvalid}, 32'd0);
        check("to_grant_off", {31'd0, grant_d}, 32'd0);
        check("to_err_off", {31'd0, bus_err}, 32'd0);
        mready = 1'b1; mrdata = 32'h5555;
        #1;
        check("to_late_ready", {30'd0, iready, dready}, 32'd0);
        check("to_drdata_hold", drdata, 32'hDEADBEEF);
        step;
        mready = 1'b0;

        // Back-to-back data reads with dvalid held
        dvalid = 1'b1; daddr = 32'h4000;
        serve("b2b0", 1'b1, 32'h2222, w);
        serve("b2b1", 1'b1, 32'h3333, w);
        check("b2b_gap", w, 32'd1);
        dvalid = 1'b0;
        step;

        // Reset asserted mid-transaction
        dvalid = 1'b1; daddr = 32'h5000;
        step;
        check("mr_grant_d", {31'd0, grant_d}, 32'd1);
        mready = 1'b1; mrdata = 32'h4444;
        #1;
        check("mr_dready_pre", {31'd0, dready}, 32'd1);
        reset = 1'b0;
        #1;
        check("mr_mvalid", {31'd0, mvalid}, 32'd0);
        check("mr_dready", {31'd0, dready}, 32'd0);
        check("mr_grant_d_off", {31'd0, grant_d}, 32'd0);
        check("mr_maddr", maddr, 32'd0);
        dvalid = 1'b0; mready = 1'b0;
        step;
        reset = 1'b1;
        ivalid = 1'b1; iaddr = 32'h40;
        serve("mr_fetch", 1'b0, 32'h1111_1111, w);
        check("mr_fetch_gap", w, 32'd1);
        ivalid = 1'b0;
        step;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL sim_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/fwrisc_mem_arbiter.md
Name: fwrisc_mem_arbiter

Overview:
Shares one single-ported memory bus between the core's instruction-fetch port (iaddr/ivalid/iready/idata) and data port (daddr/dvalid/dwrite/dwdata/dwstb/drdata/dready). It sits between the fwrisc top level and the SoC memory, and allows only one transaction in flight at a time. Arbitration is round-robin on simultaneous requests. A watchdog terminates transactions whose memory never responds and flags the event.

Parameters:
TIMEOUT, 255, memory-wait cycles before forced completion; 0 disables the watchdog; legal range 0..65535.
ERR_RDATA, 32'hDEAD_BEEF, read data returned to the requester on a timed-out transaction.

Ports:
clock  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-low reset; state clears immediately while reset==0
iaddr  input  32  fetch address
ivalid  input  1  fetch request; held by requester until iready
iready  output  1  fetch completion pulse
idata  output  32  fetch read data, valid when iready=1
daddr  input  32  data address
dvalid  input  1  data request; held until dready
dwrite  input  1  1=write, 0=read
dwdata  input  32  write data
dwstb  input  4  byte strobes
dready  output  1  data completion pulse
drdata  output  32  data read data, valid when dready=1
maddr  output  32  memory address (registered)
mvalid  output  1  memory request (registered)
mwrite  output  1  memory write (registered)
mwdata  output  32  memory write data (registered)
mwstb  output  4  memory strobes (registered; 4'hF for fetches)
mrdata  input  32  memory read data
mready  input  1  memory completion
bus_err  output  1  one-cycle pulse on watchdog expiry
grant_d  output  1  1 while the data port owns the bus (trace/debug)

Behaviour:
- Reset (reset==0, async): state=IDLE; last_grant=DATA, so a fetch wins the first contention. mvalid, mwrite, iready, dready, bus_err and grant_d are 0. maddr, mwdata, mwstb, idata and drdata are 0. The watchdog counter is 0.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE, ivalid only -> BUSY_I. IDLE, dvalid only -> BUSY_D. Both -> grant the port that is not last_grant, then update last_grant. Neither -> stay in IDLE.
- On the grant edge, register maddr/mwrite/mwdata/mwstb from the winner and set mvalid=1. Fetch transactions use mwrite=0, mwstb=4'hF, mwdata=0. Latency: request seen in cycle N gives mvalid=1 in cycle N+1.
- BUSY_x, mready=1 -> the matching ready output is asserted combinationally in the same cycle. The matching rdata is driven from mrdata (drdata from mrdata also on writes; don't-care). Next edge: mvalid=0, state=IDLE.
- The non-granted ready is always 0. idata and drdata hold their last value when not ready.
- No grant is made in the completion cycle. The earliest next mvalid is 2 cycles after the mready cycle. A waiting requester keeps its valid high and is served then.
- Address/data are latched at grant. A requester dropping valid mid-transaction (protocol violation) does not abort it; the ready pulse is still issued.
- Watchdog (TIMEOUT>0): 16-bit counter, cleared at grant, incremented each BUSY cycle with mready=0.
  - When the counter reaches TIMEOUT with mready=0: pulse the requester's ready with rdata=ERR_RDATA, pulse bus_err, deassert mvalid and return to IDLE.
  - If mready=1 in the expiry cycle, complete normally with no bus_err.
  - A late mready arriving in IDLE is ignored.
- grant_d=1 exactly while state==BUSY_D.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs at reset values. The pending requester never receives ready.

Test Plan:
- Single fetch: ivalid=1, iaddr=0x100, mem responds mready after 2 cycles with 0x00000013. Required: maddr=0x100, mwstb=F, mwrite=0; iready=1 with idata=0x13 in the mready cycle; mvalid=0 the next cycle.
- Simultaneous requests after reset: ivalid+dvalid in the same cycle. Required: fetch granted first and data second. Repeat the contention: grants alternate I, D, I, D; dready/iready are never asserted together.
- Data write: daddr=0x2004, dwdata=0xA5A5A5A5, dwstb=4'b0011, dwrite=1. Required: identical values on m* one cycle later; dready pulses with mready; mwrite=1.
- Timeout with TIMEOUT=4: data read, mready held 0. Required: dready=1 with drdata=0xDEADBEEF and bus_err=1 in the same cycle; IDLE next; a subsequent mready=1 in IDLE produces no ready.
- Reset mid-transaction: assert reset low while in BUSY_D. Required: mvalid, dready and grant_d are 0 immediately, asynchronously, before the next clock edge. After release, a new fetch completes normally.
- Back-to-back: dvalid held high through completion with a second request. Required: second mvalid appears exactly 2 cycles after the first mready cycle.
